// File: rtl/trit_pkg.sv
// Trit code constants, FSM state type and code-to-value helper shared by the trit decoder.
// TRIT_DEC_ERR_EN selects how the illegal code 11 is valued.
package trit_pkg;

  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b01;
  localparam logic [1:0] TRIT_2   = 2'b10;
  localparam logic [1:0] TRIT_BAD = 2'b11;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  function automatic logic [1:0] trit_val(input logic [1:0] code);
    logic [1:0] v;
    case (code)
      TRIT_0:  v = 2'd0;
      TRIT_1:  v = 2'd1;
      TRIT_2:  v = 2'd2;
`ifdef TRIT_DEC_ERR_EN
      // Illegal code contributes nothing; the frame is flagged instead.
      default: v = 2'd0;
`else
      // Without detection only bit 1 is looked at, so 11 reads as 2.
      default: v = 2'd2;
`endif
    endcase
    return v;
  endfunction

endpackage

// File: rtl/trit_mac.sv
// Combinational acc*3 + t step of the trit fold, all in OUT_W bits.
// Zero latency; no handshake.
module trit_mac #(
  parameter int OUT_W = 8
) (
  input  logic [OUT_W-1:0] acc_i,
  input  logic [1:0]       t_i,
  output logic [OUT_W-1:0] sum_o
);

  assign sum_o = (acc_i << 1) + acc_i + OUT_W'(t_i);

endmodule

// File: rtl/trit_stream_decoder.sv
// Serial MS-trit-first decoder folding N_TRITS trits into a word; result 1 cycle after last accept.
// trit_ready low while a word waits on out_ready; TRIT_DEC_ERR_EN builds illegal-code detection.
module trit_stream_decoder
  import trit_pkg::*;
#(
  parameter int N_TRITS = 5,
  parameter int OUT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trit_valid,
  input  logic [1:0]       trit,
  output logic             trit_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int CNT_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TRITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [OUT_W-1:0] mac_sum;

  trit_mac #(.OUT_W(OUT_W)) u_mac (
    .acc_i (acc_q),
    .t_i   (trit_val(trit)),
    .sum_o (mac_sum)
  );

`ifdef TRIT_DEC_ERR_EN
  logic err_q, err_d;
  logic out_err_q, out_err_d;
  logic trit_bad;

  assign trit_bad = (trit == TRIT_BAD);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
`ifdef TRIT_DEC_ERR_EN
    err_d      = err_q;
    out_err_d  = out_err_q;
`endif
    case (state_q)
      ST_ACC: begin
        if (trit_valid) begin
          acc_d = mac_sum;
`ifdef TRIT_DEC_ERR_EN
          err_d = err_q | trit_bad;
`endif
          if (cnt_q == CNT_LAST) begin
            state_d    = ST_DONE;
            cnt_d      = '0;
            out_data_d = mac_sum;
`ifdef TRIT_DEC_ERR_EN
            out_err_d  = err_q | trit_bad;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Accumulator is cleared on handoff so the next frame starts from zero.
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
`ifdef TRIT_DEC_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef TRIT_DEC_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      out_err_q <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  assign trit_ready = (state_q == ST_ACC);
  assign out_valid  = (state_q == ST_DONE);
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_trit_stream_decoder.sv
// Directed plus randomized frames for trit_stream_decoder (N_TRITS=5, OUT_W=8) against a positional-value model.
module tb_trit_stream_decoder;

  localparam int N     = 5;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             trit_valid;
  logic [1:0]       trit;
  logic             trit_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] fr [N];
  int         exp_val;
  logic       exp_err;
  int         frame_cycles;

  always #5 clk = ~clk;

  trit_stream_decoder #(.N_TRITS(N), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trit_valid (trit_valid),
    .trit       (trit),
    .trit_ready (trit_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame value as a base-3 positional sum; code 11 counts 0 with detection, 2 without.
  task automatic model_frame();
    int p;
    int d;
    exp_val = 0;
    exp_err = 1'b0;
    p = 1;
    for (int i = N - 1; i >= 0; i--) begin
      if (fr[i] == 2'b11) begin
`ifdef TRIT_DEC_ERR_EN
        d = 0;
        exp_err = 1'b1;
`else
        d = 2;
`endif
      end else begin
        d = int'(fr[i]);
      end
      exp_val += d * p;
      p *= 3;
    end
  endtask

  // Offers trits of fr[0..n_send-1]; mode 0 continuous, 1 alternate cycles, 2 random gaps.
  // Starts and ends just after a falling edge.
  task automatic send_trits(input int n_send, input int mode, input string tag);
    int  idx;
    int  cyc;
    bit  early_valid;
    logic rdy_seen;
    idx = 0;
    cyc = 0;
    early_valid = 1'b0;
    while (idx < n_send && cyc < 200) begin
      case (mode)
        0:       trit_valid = 1'b1;
        1:       trit_valid = (cyc % 2 == 0);
        default: trit_valid = 1'($urandom_range(0, 1));
      endcase
      trit = fr[idx];
      rdy_seen = trit_ready;
      if (out_valid) early_valid = 1'b1;
      @(posedge clk);
      if (trit_valid && rdy_seen) idx++;
      @(negedge clk);
      cyc++;
    end
    trit_valid = 1'b0;
    frame_cycles = cyc;
    chk({tag, "_accepted"}, 32'(idx), 32'(n_send));
    chk({tag, "_no_early_valid"}, 32'(early_valid), 32'd0);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ready_low"}, 32'(trit_ready), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_val));
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  // Holds the word for 'hold' cycles while offering trits, then takes it.
  task automatic consume(input int hold, input string tag);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      trit_valid = 1'b1;
      trit = 2'b10;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(trit_ready), 32'd0);
      chk({tag, "_hold_data"}, 32'(out_data), 32'(exp_val));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trit_valid = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_ready"}, 32'(trit_ready), 32'd1);
    chk({tag, "_rel_data_held"}, 32'(out_data), 32'(exp_val));
    chk({tag, "_rel_err_held"}, 32'(out_err), 32'(exp_err));
  endtask

  task automatic load(input logic [1:0] a, b, c, d, e);
    fr[0] = a; fr[1] = b; fr[2] = c; fr[3] = d; fr[4] = e;
    model_frame();
  endtask

  initial begin
    rst_n = 1'b0;
    trit_valid = 1'b0;
    trit = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ready", 32'(trit_ready), 32'd1);
    rst_n = 1'b1;

    // All-twos frame, back to back, consumer always ready.
    load(2'd2, 2'd2, 2'd2, 2'd2, 2'd2);
    chk("max_model", 32'(exp_val), 32'd242);
    out_ready = 1'b1;
    send_trits(N, 0, "max");
    chk("max_cycles", 32'(frame_cycles), 32'(N));
    check_result("max");
    @(posedge clk);
    @(negedge clk);
    chk("max_ready_back", 32'(trit_ready), 32'd1);
    chk("max_valid_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    load(2'd1, 2'd0, 2'd2, 2'd0, 2'd1);
    send_trits(N, 0, "f100");
    check_result("f100");
    consume(0, "f100");

    // Illegal code in the second position.
    load(2'd1, 2'b11, 2'd0, 2'd0, 2'd0);
    send_trits(N, 0, "bad");
    check_result("bad");
    consume(0, "bad");

    // Consumer stall with trits offered during the hold.
    load(2'd0, 2'd0, 2'd0, 2'd1, 2'd2);
    send_trits(N, 0, "hold");
    check_result("hold");
    consume(3, "hold");

    // Partial frame then reset.
    load(2'd2, 2'd1, 2'd2, 2'd0, 2'd0);
    send_trits(3, 0, "part");
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    load(2'd0, 2'd0, 2'd0, 2'd0, 2'd1);
    send_trits(N, 0, "after_rst");
    check_result("after_rst");
    consume(0, "after_rst");

    // Alternating trit_valid.
    load(2'd2, 2'd1, 2'd0, 2'd1, 2'd2);
    chk("gap_model", 32'(exp_val), 32'd194);
    send_trits(N, 1, "gap");
    chk("gap_cycles", 32'(frame_cycles), 32'(2 * N - 1));
    check_result("gap");
    consume(1, "gap");

    // Reset while a word is pending.
    load(2'd1, 2'd1, 2'd1, 2'd1, 2'd1);
    send_trits(N, 0, "drop");
    check_result("drop");
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("drop_ready", 32'(trit_ready), 32'd1);
    chk("drop_data", 32'(out_data), 32'd0);

    // Random frames with random gaps and stalls.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < N; i++) fr[i] = 2'($urandom_range(0, 3));
      model_frame();
      send_trits(N, 2, "rnd");
      check_result("rnd");
      consume(int'($urandom_range(0, 3)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
